// File: rtl/vga_scan_gen.sv
// VGA raster generator that fetches framebuffer pixels PIPE clocks ahead and
// delays sync/blank/position so they line up with the returned pixel data.
module vga_scan_gen #(
    parameter int CW    = 12,
    parameter int AW    = 19,
    parameter int HSIZE = 800,
    parameter int HFP   = 856,
    parameter int HSP   = 976,
    parameter int HMAX  = 1040,
    parameter int VSIZE = 600,
    parameter int VFP   = 637,
    parameter int VSP   = 643,
    parameter int VMAX  = 666,
    parameter bit HSPP  = 1'b1,
    parameter bit VSPP  = 1'b1,
    parameter int PIPE  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [AW-1:0] fb_base,
    output logic          fetch_en,
    output logic [AW-1:0] fetch_addr,
    output logic          hsync,
    output logic          vsync,
    output logic          data_enable,
    output logic [CW-1:0] hdata,
    output logic [CW-1:0] vdata,
    output logic          frame_start,
    output logic          vblank_irq
);

    localparam logic [CW-1:0] H_VIS  = CW'(HSIZE);
    localparam logic [CW-1:0] H_SYNA = CW'(HFP);
    localparam logic [CW-1:0] H_SYNB = CW'(HSP);
    localparam logic [CW-1:0] H_LAST = CW'(HMAX - 1);
    localparam logic [CW-1:0] V_VIS  = CW'(VSIZE);
    localparam logic [CW-1:0] V_SYNA = CW'(VFP);
    localparam logic [CW-1:0] V_SYNB = CW'(VSP);
    localparam logic [CW-1:0] V_LAST = CW'(VMAX - 1);

    logic          running;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          h_end;
    logic          v_end;
    logic          boundary;

    assign h_end    = (hcount == H_LAST);
    assign v_end    = (vcount == V_LAST);
    // A stopped generator treats every edge as a frame boundary so en and
    // fb_base are picked up on the very next clock.
    assign boundary = !running || (h_end && v_end);
    assign fetch_en = running && (hcount < H_VIS) && (vcount < V_VIS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running    <= 1'b0;
            hcount     <= '0;
            vcount     <= '0;
            fetch_addr <= '0;
        end else if (boundary) begin
            running    <= en;
            hcount     <= '0;
            vcount     <= '0;
            fetch_addr <= fb_base;
        end else begin
            hcount <= h_end ? '0 : hcount + CW'(1);
            if (h_end) begin
                vcount <= v_end ? '0 : vcount + CW'(1);
            end
            if (fetch_en) begin
                fetch_addr <= fetch_addr + AW'(1);
            end
        end
    end

    // Raw decode of the current raster position (inactive while stopped)
    logic          hs_raw;
    logic          vs_raw;
    logic          fs_raw;
    logic          vb_raw;
    logic [CW-1:0] h_raw;
    logic [CW-1:0] v_raw;

    always_comb begin
        hs_raw = ~HSPP;
        vs_raw = ~VSPP;
        fs_raw = 1'b0;
        vb_raw = 1'b0;
        h_raw  = '0;
        v_raw  = '0;
        if (running) begin
            if (hcount >= H_SYNA && hcount < H_SYNB) hs_raw = HSPP;
            if (vcount >= V_SYNA && vcount < V_SYNB) vs_raw = VSPP;
            fs_raw = (hcount == '0) && (vcount == '0);
            vb_raw = (hcount == '0) && (vcount == V_VIS);
            h_raw  = hcount;
            v_raw  = vcount;
        end
    end

    // Delay line: stage 0 captures the raw decode, stage PIPE-1 drives the pins
    logic          hs_p [PIPE];
    logic          vs_p [PIPE];
    logic          de_p [PIPE];
    logic          fs_p [PIPE];
    logic          vb_p [PIPE];
    logic [CW-1:0] h_p  [PIPE];
    logic [CW-1:0] v_p  [PIPE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE; i++) begin
                hs_p[i] <= ~HSPP;
                vs_p[i] <= ~VSPP;
                de_p[i] <= 1'b0;
                fs_p[i] <= 1'b0;
                vb_p[i] <= 1'b0;
                h_p[i]  <= '0;
                v_p[i]  <= '0;
            end
        end else begin
            hs_p[0] <= hs_raw;
            vs_p[0] <= vs_raw;
            de_p[0] <= fetch_en;
            fs_p[0] <= fs_raw;
            vb_p[0] <= vb_raw;
            h_p[0]  <= h_raw;
            v_p[0]  <= v_raw;
            for (int i = 1; i < PIPE; i++) begin
                hs_p[i] <= hs_p[i-1];
                vs_p[i] <= vs_p[i-1];
                de_p[i] <= de_p[i-1];
                fs_p[i] <= fs_p[i-1];
                vb_p[i] <= vb_p[i-1];
                h_p[i]  <= h_p[i-1];
                v_p[i]  <= v_p[i-1];
            end
        end
    end

    assign hsync       = hs_p[PIPE-1];
    assign vsync       = vs_p[PIPE-1];
    assign data_enable = de_p[PIPE-1];
    assign frame_start = fs_p[PIPE-1];
    assign vblank_irq  = vb_p[PIPE-1];
    assign hdata       = h_p[PIPE-1];
    assign vdata       = v_p[PIPE-1];

endmodule

// File: tb/tb_vga_scan_gen.sv
// Randomized scoreboard bench for vga_scan_gen using the small raster timing.
module tb_vga_scan_gen;

    localparam int CW = 12, AW = 19;
    localparam int HS = 4, HF = 5, HP = 6, HM = 8;
    localparam int VS = 3, VF = 4, VP = 5, VM = 6;
    localparam int PIPE = 2;
    localparam int TOT = HM * VM;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [AW-1:0] fb_base = '0;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic          hsync, vsync, data_enable, frame_start, vblank_irq;
    logic [CW-1:0] hdata, vdata;

    vga_scan_gen #(
        .CW(CW), .AW(AW), .HSIZE(HS), .HFP(HF), .HSP(HP), .HMAX(HM),
        .VSIZE(VS), .VFP(VF), .VSP(VP), .VMAX(VM), .HSPP(1'b1), .VSPP(1'b1),
        .PIPE(PIPE)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .fb_base(fb_base),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .hsync(hsync), .vsync(vsync), .data_enable(data_enable),
        .hdata(hdata), .vdata(vdata),
        .frame_start(frame_start), .vblank_irq(vblank_irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] hd;
        logic [CW-1:0] vd;
        logic          fs;
        logic          vb;
    } out_t;

    localparam out_t IDLE = '0;

    int   checks = 0;
    int   failures = 0;
    out_t q[$];

    // Reference model: frame position counter plus latched run/base state
    bit            m_run = 1'b0;
    int            m_pos = 0;
    logic [AW-1:0] m_base = '0;

    function automatic out_t expect_out(input bit r, input int p);
        out_t o;
        int h, v;
        o = IDLE;
        h = p % HM;
        v = p / HM;
        if (r) begin
            o.hs = (h >= HF) && (h < HP);
            o.vs = (v >= VF) && (v < VP);
            o.de = (h < HS) && (v < VS);
            o.hd = CW'(h);
            o.vd = CW'(v);
            o.fs = (p == 0);
            o.vb = (h == 0) && (v == VS);
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    initial begin
        repeat (PIPE) q.push_back(IDLE);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_run = 1'b0;
                m_pos = 0;
                m_base = '0;
                q.delete();
                repeat (PIPE) q.push_back(IDLE);
            end else begin
                if (!m_run || m_pos == TOT - 1) begin
                    m_run  = en;
                    m_base = fb_base;
                    m_pos  = 0;
                end else begin
                    m_pos++;
                end
                q.push_back(expect_out(m_run, m_pos));
            end
        end
    end

    // Monitor: compares pins and the fetch port on every falling edge
    initial begin
        out_t act, req;
        int h, v;
        bit fe;
        logic [AW-1:0] addr;
        forever begin
            @(negedge clk);
            act = '{hsync, vsync, data_enable, hdata, vdata, frame_start, vblank_irq};
            if (rst) begin
                check("reset_outputs", 64'(act), 64'(IDLE));
            end else if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty t=%0t actual=0 required=1", $time);
            end else begin
                req = q.pop_front();
                check("pixel_outputs", 64'(act), 64'(req));
            end
            h  = m_pos % HM;
            v  = m_pos / HM;
            fe = m_run && (h < HS) && (v < VS);
            check("fetch_en", 64'(fetch_en), 64'(fe));
            if (fe) begin
                addr = m_base + AW'(v * HS + h);
                check("fetch_addr", 64'(fetch_addr), 64'(addr));
            end
        end
    end

    initial begin
        bool_found: begin end
        repeat (3) @(posedge clk);
        @(negedge clk);
        en = 1'b1;
        fb_base = AW'(100);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_fetch_en", 64'(fetch_en), 64'(1));
        check("first_fetch_addr", 64'(fetch_addr), 64'(100));
        repeat (2) @(posedge clk);
        #1;
        check("first_de", 64'({data_enable, hdata, vdata}), 64'({1'b1, 12'd0, 12'd0}));
        repeat (60) @(negedge clk);

        // mid-frame base change at h=2, v=1
        for (int i = 0; i < 200 && !(m_run && m_pos == HM + 2); i++) @(negedge clk);
        fb_base = AW'(200);
        repeat (120) @(negedge clk);

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) fb_base = AW'($urandom);
            if ($urandom_range(0, 149) == 0) en = ~en;
        end
        en = 1'b1;

        fb_base = AW'((1 << AW) - 5);
        repeat (150) @(negedge clk);

        // stop during line 1, then restart
        for (int i = 0; i < 200 && !(m_run && m_pos / HM == 1); i++) @(negedge clk);
        en = 1'b0;
        repeat (80) @(negedge clk);
        en = 1'b1;
        fb_base = AW'(300);
        repeat (60) @(negedge clk);

        // async reset while a pixel is on the outputs
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                seen = data_enable;
            end
            check("de_seen_before_reset", 64'(seen), 64'(1));
        end
        #3 rst = 1'b1;
        #1;
        check("async_reset_pins", 64'({hsync, vsync, data_enable, frame_start, vblank_irq}), 64'(0));
        en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (6) @(negedge clk);
        en = 1'b1;
        repeat (100) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
